// File: rtl/arb_pkg.sv
// Shared types and sizing for the 8-way round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 8;

endpackage

// File: rtl/decoder38.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module decoder38 (
  input  logic [2:0] in,
  input  logic       en,
  output logic [7:0] out
);

  always_comb begin
    out = 8'h00;
    if (en) out[in] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with optional per-owner hold limit.
//
// state | meaning
// IDLE  | no owner; next cycle grants the first requester at or after ptr
// GRANT | gnt_idx owns the slot until request drop, en low or hold limit
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EN ? MAX_HOLD - 1 : 0);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;

  logic               owner_req;
  logic               hold_hit;

  // Scan downward so the offset closest to ptr is the last (winning) match.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req_i,
                                               input logic [IDX_W-1:0]   ptr_i);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    pick = ptr_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr_i + IDX_W'(k);
      if (req_i[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign owner_req = req[gnt_idx_q];
  assign hold_hit  = HOLD_EN && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_idx_d  = gnt_idx_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && (req != '0)) begin
          gnt_idx_d  = rr_pick(req, ptr_q);
          hold_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!en || !owner_req || hold_hit) begin
          state_d   = IDLE;
          ptr_d     = gnt_idx_q + IDX_W'(1);
          timeout_d = en && owner_req;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = (state_q == GRANT);
  assign timeout   = timeout_q;

  decoder38 u_dec (
    .in  (gnt_idx_q),
    .en  (gnt_valid),
    .out (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and random checks of rr_arbiter8 (hold limit 4 and unlimited) against a reference model.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;

  logic [7:0] gnt4, gnt0;
  logic [2:0] idx4, idx0;
  logic       vld4, vld0;
  logic       to4, to0;

  int n_chk  = 0;
  int n_fail = 0;

  int m_valid [2];
  int m_idx   [2];
  int m_ptr   [2];
  int m_held  [2];
  int m_to    [2];

  logic [9:0] vseq, tseq;

  rr_arbiter8 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(vld4), .timeout(to4)
  );

  rr_arbiter8 #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(vld0), .timeout(to0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour: held counts cycles owned so far; limit n ends ownership after n cycles.
  task automatic model_step(input int u, input int n);
    bit found;
    if (rst) begin
      m_valid[u] = 0; m_idx[u] = 0; m_ptr[u] = 0; m_held[u] = 0; m_to[u] = 0;
    end else if (m_valid[u] == 0) begin
      m_to[u] = 0;
      if (en && req != 8'h00) begin
        found = 0;
        for (int k = 0; k < 8; k++) begin
          if (!found && req[(m_ptr[u] + k) % 8]) begin
            m_idx[u] = (m_ptr[u] + k) % 8;
            found = 1;
          end
        end
        m_valid[u] = 1;
        m_held[u]  = 1;
      end
    end else begin
      if (!en || !req[m_idx[u]] || (n != 0 && m_held[u] == n)) begin
        m_to[u]    = (en && req[m_idx[u]]) ? 1 : 0;
        m_valid[u] = 0;
        m_ptr[u]   = (m_idx[u] + 1) % 8;
      end else begin
        m_held[u]++;
        m_to[u] = 0;
      end
    end
  endtask

  function automatic logic [31:0] exp_gnt(input int u);
    return (m_valid[u] != 0) ? (32'd1 << m_idx[u]) : 32'd0;
  endfunction

  task automatic cyc(input logic r, input logic e, input logic [7:0] q);
    rst = r; en = e; req = q;
    @(posedge clk);
    model_step(0, 4);
    model_step(1, 0);
    @(negedge clk);
    chk("gnt_h4",   32'(gnt4), exp_gnt(0));
    chk("idx_h4",   32'(idx4), 32'(m_idx[0]));
    chk("valid_h4", 32'(vld4), 32'(m_valid[0]));
    chk("tout_h4",  32'(to4),  32'(m_to[0]));
    chk("gnt_h0",   32'(gnt0), exp_gnt(1));
    chk("idx_h0",   32'(idx0), 32'(m_idx[1]));
    chk("valid_h0", 32'(vld0), 32'(m_valid[1]));
    chk("tout_h0",  32'(to0),  32'(m_to[1]));
  endtask

  initial begin
    logic [7:0] rq;
    logic       re, rr;
    rst = 1'b1; en = 1'b0; req = 8'h00;
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 0; m_idx[u] = 0; m_ptr[u] = 0; m_held[u] = 0; m_to[u] = 0;
    end

    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00);
    chk("reset_gnt", 32'(gnt4), 32'h00);
    chk("reset_valid", 32'(vld0), 32'h0);

    // basic grant and handoff
    cyc(0, 1, 8'h05);
    chk("first_gnt", 32'(gnt4), 32'h01);
    chk("first_idx", 32'(idx4), 32'h0);
    cyc(0, 1, 8'h05);
    cyc(0, 1, 8'h04);
    chk("handoff_gap", 32'(gnt4), 32'h00);
    cyc(0, 1, 8'h04);
    chk("second_gnt", 32'(gnt4), 32'h04);
    chk("second_idx", 32'(idx4), 32'h2);
    cyc(0, 1, 8'h00);

    // fairness: every owner drops after two cycles
    cyc(1, 0, 8'h00);
    for (int g = 0; g < 9; g++) begin
      cyc(0, 1, 8'hFF);
      chk("fair_idx", 32'(idx0), 32'(g % 8));
      cyc(0, 1, 8'hFF);
      rq = 8'hFF & ~(8'h01 << (g % 8));
      cyc(0, 1, rq);
      chk("fair_gap", 32'(vld0), 32'h0);
    end

    // wrap: owner 7 hits the limit with requester 1 waiting
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'h80);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h82);
    chk("wrap_tout", 32'(to4), 32'h1);
    cyc(0, 1, 8'h82);
    chk("wrap_gnt", 32'(gnt4), 32'h02);

    // hold limit pattern with requester 0 held
    cyc(1, 0, 8'h00);
    vseq = '0; tseq = '0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 8'h01);
      vseq = {vseq[8:0], vld4};
      tseq = {tseq[8:0], to4};
    end
    chk("limit_valid_seq", 32'(vseq), 32'(10'b1111011110));
    chk("limit_tout_seq",  32'(tseq), 32'(10'b0000100001));

    // en low mid-grant releases without timeout and blocks new grants
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'h08);
    chk("en_owner", 32'(idx4), 32'h3);
    cyc(0, 0, 8'h08);
    chk("en_drop_gnt", 32'(gnt4), 32'h00);
    chk("en_drop_tout", 32'(to4), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 8'hFF);
      chk("en_low_block", 32'(gnt0), 32'h00);
    end
    cyc(0, 1, 8'hFF);
    chk("en_ptr_next", 32'(idx4), 32'h4);

    // reset during a grant
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'h20);
    chk("rst_owner", 32'(idx4), 32'h5);
    cyc(1, 1, 8'h20);
    chk("rst_gnt", 32'(gnt4), 32'h00);
    cyc(0, 1, 8'hFF);
    chk("rst_prio", 32'(idx0), 32'h0);

    // long ownership: unlimited owner keeps the slot well past counter saturation
    for (int i = 0; i < 300; i++) cyc(0, 1, 8'h01);
    chk("unlimited_hold", 32'(vld0), 32'h1);

    // random traffic
    rq = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) rq = 8'h00;
      re = ($urandom_range(0, 9) != 0);
      rr = ($urandom_range(0, 199) == 0);
      cyc(rr, re, rq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
